// File: rtl/pipe2pull_pkg.sv
// ---------------------------------------------------------------------------
// pipe2pull_pkg
//
// Purpose:
//   Shared helpers for the pipe2pull block and its storage sub-module.
//
// Contents:
//   ptrWidth(depth) - number of bits needed to address 'depth' entries.
//                     Returns at least 1 so that a degenerate depth still
//                     yields a legal vector width.
// ---------------------------------------------------------------------------
package pipe2pull_pkg;

    // Address width for a buffer of the given depth. The depth does not have
    // to be a power of two, so pointers wrap explicitly rather than by
    // natural overflow.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe2pull_pull_ram.sv
// ---------------------------------------------------------------------------
// pull_ram
//
// Purpose:
//   DEPTH x WIDTH register array with one synchronous write port and one
//   registered read port. The read register is the pull-side data output:
//   it only changes when a read is enabled and holds its value otherwise.
//
// Ports:
//   clock    in   rising-edge clock
//   resetn   in   asynchronous active-low reset (clears the read register)
//   i_wen    in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_ren    in   read enable
//   i_raddr  in   read address
//   o_rdata  out  registered read data
// ---------------------------------------------------------------------------
module pull_ram
    import pipe2pull_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ptrWidth(DEPTH)
)
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array carries no reset: stale contents are never observable
    // because the controller only reads entries it has written since reset.
    always_ff @(posedge clock) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Output register: cleared by reset so the consumer sees zero until the
    // first real read, and held between reads.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (i_ren) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pipe2pull.sv
// ---------------------------------------------------------------------------
// pipe2pull
//
// Purpose:
//   Converts a valid/ready pipe stream into a FIFO-style pull interface.
//   Words accepted on the pipe side are stored in a circular buffer; the
//   consumer asserts ordem while oempty is low and receives the word on
//   odata one clock later. Ordering is strict FIFO.
//
// Ports:
//   clock      in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   idata      in   pipe input data
//   ivalid     in   pipe input valid
//   iready     out  pipe input ready (transfer on ivalid && iready)
//   odata      out  registered pull data, updated after an accepted read
//   oempty     out  high when no word is available
//   ordem      in   read enable from the consumer
//   level      out  number of stored words
//   underflow  out  sticky flag, set by a read request while empty
// ---------------------------------------------------------------------------
module pipe2pull
    import pipe2pull_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
)
(
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [WIDTH-1:0]       idata,
    input  logic                   ivalid,
    output logic                   iready,
    output logic [WIDTH-1:0]       odata,
    output logic                   oempty,
    input  logic                   ordem,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   underflow
);

    localparam int                     PTR_W      = ptrWidth(DEPTH);
    localparam logic [PTR_W-1:0]       LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(DEPTH);

    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   r_underflow;

    logic                   w_iready;
    logic                   w_oempty;
    logic                   w_itransfer;
    logic                   w_rtransfer;

    // Flow-control flags come only from the registered level, so there is no
    // combinational path from ivalid/ordem to iready/oempty. This also means
    // a word written into an empty buffer cannot be read in the same cycle,
    // and a read from a full buffer frees a slot only from the next cycle.
    assign w_iready    = (r_level != FULL_LEVEL);
    assign w_oempty    = (r_level == '0);
    assign w_itransfer = ivalid && w_iready;
    assign w_rtransfer = ordem && !w_oempty;

    // Pointers, occupancy and the sticky underflow flag. Pointers wrap
    // explicitly at DEPTH-1 because DEPTH need not be a power of two. The
    // level cannot leave 0..DEPTH since the transfers are gated by the flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_itransfer) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_rtransfer) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PTR_W'(1);
            end
            r_level <= r_level + LEVEL_WIDTH'(w_itransfer)
                               - LEVEL_WIDTH'(w_rtransfer);
            if (ordem && w_oempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    pull_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clock   (clock),
        .resetn  (resetn),
        .i_wen   (w_itransfer),
        .i_waddr (r_wptr),
        .i_wdata (idata),
        .i_ren   (w_rtransfer),
        .i_raddr (r_rptr),
        .o_rdata (odata)
    );

    assign iready    = w_iready;
    assign oempty    = w_oempty;
    assign level     = r_level;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pipe2pull.sv
// ---------------------------------------------------------------------------
// tb_pipe2pull
//
// Purpose:
//   Self-checking bench for pipe2pull (WIDTH=8, DEPTH=4). A queue-based
//   model of the buffer tracks what the outputs must be; a compare process
//   checks every output against it on each falling edge, and the directed
//   sequence adds hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_pipe2pull;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int LEVEL_WIDTH = $clog2(DEPTH + 1);

    logic                   clock;
    logic                   resetn;
    logic [WIDTH-1:0]       idata;
    logic                   ivalid;
    logic                   iready;
    logic [WIDTH-1:0]       odata;
    logic                   oempty;
    logic                   ordem;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   underflow;

    int numVectors     = 0;
    int numMiscompares = 0;

    pipe2pull #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .LEVEL_WIDTH (LEVEL_WIDTH)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .idata     (idata),
        .ivalid    (ivalid),
        .iready    (iready),
        .odata     (odata),
        .oempty    (oempty),
        .ordem     (ordem),
        .level     (level),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: a queue holding the stored words in arrival order,
    // the last word handed to the consumer, and the sticky error flag.
    logic [WIDTH-1:0] modelQ[$];
    logic [WIDTH-1:0] modelOdata = '0;
    logic             modelUnder = 1'b0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            modelQ.delete();
            modelOdata = '0;
            modelUnder = 1'b0;
        end else begin
            automatic bit canWrite = (modelQ.size() < DEPTH);
            automatic bit canRead  = (modelQ.size() > 0);
            if (ordem && !canRead) modelUnder = 1'b1;
            if (ordem && canRead) modelOdata = modelQ.pop_front();
            if (ivalid && canWrite) modelQ.push_back(idata);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numVectors++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (resetn) begin
            checkOutput("model.odata",     32'(odata),     32'(modelOdata));
            checkOutput("model.level",     32'(level),     32'(modelQ.size()));
            checkOutput("model.oempty",    32'(oempty),    32'(modelQ.size() == 0));
            checkOutput("model.iready",    32'(iready),    32'(modelQ.size() < DEPTH));
            checkOutput("model.underflow", 32'(underflow), 32'(modelUnder));
        end
    end

    // Drive one cycle of inputs (we sit 1 ns after a rising edge), let the
    // next rising edge consume them, and return 1 ns after that edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic r);
        ivalid = v;
        idata  = d;
        ordem  = r;
        @(posedge clock);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".level"},     32'(level),     32'd0);
        checkOutput({tag, ".iready"},    32'(iready),    32'd1);
        checkOutput({tag, ".oempty"},    32'(oempty),    32'd1);
        checkOutput({tag, ".odata"},     32'(odata),     32'h00);
        checkOutput({tag, ".underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        resetn = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        ordem  = 1'b0;

        // Reset asserted mid-cycle; outputs must clear immediately.
        #1 resetn = 1'b0;
        #1 checkResetState("reset0");
        @(posedge clock);
        #1;
        checkResetState("reset0.held");
        #2 resetn = 1'b1;
        @(posedge clock);
        #1;

        // Single word through the buffer.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("single.oempty", 32'(oempty), 32'd0);
        checkOutput("single.level",  32'(level),  32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("single.odata",  32'(odata),  32'hA5);
        checkOutput("single.oempty", 32'(oempty), 32'd1);
        checkOutput("single.level",  32'(level),  32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Fill to full; the fifth word is refused.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0);
        end
        checkOutput("fill.level",  32'(level),  32'd4);
        checkOutput("fill.iready", 32'(iready), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("fill.hold",   32'(level),  32'd4);

        // Read while full: no same-cycle write, ready returns next cycle.
        applyStimulus(1'b1, 8'h05, 1'b1);
        checkOutput("full.odata",  32'(odata),  32'h01);
        checkOutput("full.level",  32'(level),  32'd3);
        checkOutput("full.iready", 32'(iready), 32'd1);
        applyStimulus(1'b1, 8'h05, 1'b0);
        checkOutput("full.refill", 32'(level),  32'd4);
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("drain.odata", 32'(odata), 32'(k));
        end
        checkOutput("drain.oempty", 32'(oempty), 32'd1);

        // Streaming with ordem held high after the first word lands.
        applyStimulus(1'b1, 8'h10, 1'b0);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b1, 8'(8'h10 + k), 1'b1);
            checkOutput("stream.odata", 32'(odata), 32'(8'h10 + k - 1));
            checkOutput("stream.level", 32'(level), 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("stream.last", 32'(odata), 32'h17);
        checkOutput("stream.empty", 32'(oempty), 32'd1);
        ordem = 1'b0;

        // Ten write/read pairs carry both pointers across the wrap.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 8'(8'h40 + k), 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("wrap.odata", 32'(odata), 32'(8'h40 + k));
        end
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Underflow: flag sets, data is unchanged, flag stays through traffic.
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("under.flag",  32'(underflow), 32'd1);
        checkOutput("under.odata", 32'(odata),     32'h49);
        checkOutput("under.level", 32'(level),     32'd0);
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("under.after.odata", 32'(odata),     32'h77);
        checkOutput("under.sticky",      32'(underflow), 32'd1);

        // Reset mid-operation discards a stored word and clears the flag.
        applyStimulus(1'b1, 8'h88, 1'b0);
        checkOutput("prereset.level", 32'(level), 32'd1);
        ivalid = 1'b0;
        resetn = 1'b0;
        #1 checkResetState("reset1");
        #1 resetn = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkResetState("reset1.after");

        $display("== %0d vectors applied, %0d miscompares ==",
                 numVectors, numMiscompares);
        $finish;
    end

endmodule

// File: doc/pipe2pull.md
Name: pipe2pull

Overview:
- Converts a valid/ready pipe stream into a "pull" interface.
- In the pull interface, the consumer asserts rden while empty is low, and data is presented one clock cycle later.
- It is the consumer-facing counterpart of pull2pipe. It sits between any pipe producer (counter, fifo, pipe) and a block that expects FIFO-style read semantics.
- Internal circular buffer of DEPTH entries decouples the two sides.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, buffer capacity in words; any integer >= 2, not required to be a power of two.
- LEVEL_WIDTH, $clog2(DEPTH + 1), width of the occupancy output.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  reset, asynchronous, active-low.
- idata  input  WIDTH  pipe input data.
- ivalid  input  1  pipe input valid.
- iready  output  1  pipe input ready; transfer when ivalid && iready at the clock edge.
- odata  output  WIDTH  pull data, registered, updated the cycle after an accepted read.
- oempty  output  1  high when no word is available to read.
- ordem  input  1  read enable from the consumer.
- level  output  LEVEL_WIDTH  current number of stored words.
- underflow  output  1  sticky error flag: ordem seen while oempty.

Behaviour:
- Reset (asynchronous, resetn low):
  - level=0, write/read pointers=0, odata=0, underflow=0.
  - Consequently iready=1 and oempty=1 during and after reset.
  - Reset mid-operation discards all stored words; no partial transfer completes.
- Derived outputs, decoded from registered level only (no combinational path from ivalid/ordem):
  - iready = (level != DEPTH).
  - oempty = (level == 0).
- Write, defined as itransfer = ivalid && iready:
  - mem[wptr] <= idata.
  - wptr wraps from DEPTH-1 to 0.
- Read, defined as rtransfer = ordem && !oempty:
  - odata <= mem[rptr].
  - rptr wraps from DEPTH-1 to 0.
  - odata holds its value in all cycles without rtransfer.
- Level update:
  - level <= level + itransfer - rtransfer.
  - Simultaneous write and read leaves level unchanged.
  - Arithmetic is done at LEVEL_WIDTH bits; it never over- or underflows, because iready and oempty gate the transfers.
- Latency:
  - A word accepted at edge N makes oempty low after edge N.
  - A read at edge N+1 puts that word on odata after edge N+1.
  - Minimum idata->odata latency is 2 cycles.
- Empty boundary: a write into an empty buffer cannot be read in the same cycle (oempty is still high); no bypass path.
- Full boundary: iready is low. A read in that cycle does not enable a same-cycle write; iready rises the next cycle.
- Consumer may hold ordem high continuously; one word per cycle is delivered while level > 0.
- Underflow:
  - ordem && oempty at a clock edge sets underflow <= 1.
  - It stays set until reset.
  - odata and pointers are unchanged on an underflowing read.
- Ordering: strict FIFO; no word is dropped or duplicated.

Decomposition:
- No shared package constants are needed; LEVEL_WIDTH is the only derived constant and stays a module parameter.
- One natural sub-module: pull_ram, a DEPTH x WIDTH register array with one synchronous write port and one registered read port (odata register inside).
- Pointers, level, flags stay in pipe2pull.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset: pulse resetn low mid-cycle with ordem=0 -> immediately level=0, iready=1, oempty=1, odata=0x00, underflow=0.
2. Single word: ivalid=1, idata=0xA5 for one cycle -> next cycle oempty=0, level=1; then ordem=1 for one cycle -> next cycle odata=0xA5, oempty=1, level=0.
3. Fill/full: write 0x01..0x05 back-to-back with ordem=0 -> 0x01..0x04 accepted, iready=0 while 0x05 is offered, level=4; no further level change.
4. Streaming: ivalid=1 with incrementing data from 0x10 and ordem held high -> after the 2-cycle fill, odata yields 0x10,0x11,0x12,... one per cycle, level stays 1, no gaps.
5. Wrap-around: 10 write/read pairs across the pointer wrap -> odata sequence exactly matches input order.
6. Underflow: ordem=1 with oempty=1 -> underflow=1 next cycle, odata unchanged; it stays 1 through later normal traffic until resetn is pulsed.
